// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle RV32I control FSM driving datapath selects/enables and the memory handshake
// Define MC_CTRL_PERF_CNT_EN to build the cycle/instret counters; otherwise both read 0.
module mc_ctrl_fsm #(
  parameter int STATE_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_SYS = 7'b1110011;
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
    ALUWB, BRANCH, JAL, JALR, LUI, HALT, TRAP
  } state_t;
  state_t state, state_nx, dec_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= state_nx;
  assign dec_nx = (op == OP_LOAD || op == OP_STORE) ? MEMADR :
                  op == OP_R     ? EXECUTER :
                  op == OP_I     ? EXECUTEI :
                  op == OP_BR    ? BRANCH :
                  op == OP_JAL   ? JAL :
                  op == OP_JALR  ? JALR :
                  op == OP_LUI   ? LUI :
                  op == OP_AUIPC ? ALUWB :
                  op == OP_SYS   ? HALT : TRAP;
  assign ImmSrc = op == OP_STORE ? 3'b001 :
                  op == OP_BR    ? 3'b010 :
                  op == OP_JAL   ? 3'b011 :
                  (op == OP_LUI || op == OP_AUIPC) ? 3'b100 : 3'b000;
  always_comb begin
    state_nx = state;
    mem_req = 1'b0;
    AdrSrc = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    Branch = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    halted = 1'b0;
    illegal = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        state_nx = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_nx = dec_nx;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_nx = op == OP_LOAD ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc = 1'b1;
        state_nx = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite = 1'b1;
        state_nx = FETCH;
      end
      MEMWRITE: begin
        mem_req = 1'b1;
        AdrSrc = 1'b1;
        MemWrite = 1'b1;
        state_nx = mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b10;
        state_nx = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp = 2'b10;
        state_nx = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_nx = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp = 2'b01;
        Branch = 1'b1;
        state_nx = FETCH;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_nx = ALUWB;
      end
      JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_nx = JAL;
      end
      LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_nx = ALUWB;
      end
      HALT: begin
        halted = 1'b1;
        state_nx = resume ? FETCH : HALT;
      end
      TRAP: illegal = 1'b1;
      default: state_nx = FETCH;
    endcase
    // reset must kill in-flight strobes before the clock edge, not after it
    if (!rst_n) begin
      mem_req = 1'b0;
      IRWrite = 1'b0;
      PCWrite = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      Branch = 1'b0;
    end
  end
`ifdef MC_CTRL_PERF_CNT_EN
  logic retire;
  assign retire = state_nx == FETCH &&
                  (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BRANCH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cycle_cnt <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != HALT && state != TRAP) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
    end
`else
  assign cycle_cnt = '0;
  assign instret_cnt = '0;
`endif
endmodule
